// File: rtl/bananachine_pkg.sv
// Shared definitions for the Bananachine 16-bit control path.
// Holds ALU operation codes, opcode/ext field values, branch condition codes,
// PSR bit positions, the control-FSM state encoding and the instruction
// decoder used by the controller.
package bananachine_pkg;

    localparam logic [4:0] ALU_AND   = 5'd0;
    localparam logic [4:0] ALU_OR    = 5'd1;
    localparam logic [4:0] ALU_XOR   = 5'd2;
    localparam logic [4:0] ALU_ADD   = 5'd3;
    localparam logic [4:0] ALU_SUB   = 5'd4;
    localparam logic [4:0] ALU_CMP   = 5'd5;
    localparam logic [4:0] ALU_MOV   = 5'd6;
    localparam logic [4:0] ALU_LSH   = 5'd7;
    localparam logic [4:0] ALU_LUI   = 5'd8;
    localparam logic [4:0] ALU_JCOND = 5'd9;
    localparam logic [4:0] ALU_JAL   = 5'd10;
    localparam logic [4:0] ALU_ADDU  = 5'd11;

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_SPECIAL = 4'b0100;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_BCOND   = 4'b1100;
    localparam logic [3:0] OP_LUI     = 4'b1111;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;

    // Arithmetic group: the register-form ext and the immediate-form op
    // share the same 4-bit values.
    localparam logic [3:0] CODE_AND  = 4'b0001;
    localparam logic [3:0] CODE_OR   = 4'b0010;
    localparam logic [3:0] CODE_XOR  = 4'b0011;
    localparam logic [3:0] CODE_ADD  = 4'b0101;
    localparam logic [3:0] CODE_ADDU = 4'b0110;
    localparam logic [3:0] CODE_SUB  = 4'b1001;
    localparam logic [3:0] CODE_CMP  = 4'b1011;
    localparam logic [3:0] CODE_MOV  = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_MEM    = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_DISP = 2'd1;
    localparam logic [1:0] PC_SEL_REG  = 2'd2;

    typedef enum logic [2:0] {
        K_NOP, K_ALU, K_LOAD, K_STOR, K_BCOND, K_JCOND, K_JAL
    } instr_kind_e;

    typedef struct packed {
        instr_kind_e kind;
        logic [4:0]  alu;
        logic        b_imm;
        logic        zext;
        logic        rf_wr;
        logic [7:0]  flag_mask;   // PSR bits this instruction may update
    } decode_t;

    function automatic logic arith_valid(input logic [3:0] code);
        return code inside {CODE_AND, CODE_OR, CODE_XOR, CODE_ADD,
                            CODE_ADDU, CODE_SUB, CODE_CMP, CODE_MOV};
    endfunction

    function automatic logic [4:0] arith_alu(input logic [3:0] code);
        logic [4:0] a;
        case (code)
            CODE_OR:   a = ALU_OR;
            CODE_XOR:  a = ALU_XOR;
            CODE_ADD:  a = ALU_ADD;
            CODE_ADDU: a = ALU_ADDU;
            CODE_SUB:  a = ALU_SUB;
            CODE_CMP:  a = ALU_CMP;
            CODE_MOV:  a = ALU_MOV;
            default:   a = ALU_AND;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] flag_mask_of(input logic [4:0] alu);
        logic [7:0] m;
        m = '0;
        if (alu == ALU_ADD || alu == ALU_SUB) begin
            m[PSR_C] = 1'b1;
            m[PSR_F] = 1'b1;
        end else if (alu == ALU_CMP) begin
            m[PSR_N] = 1'b1;
            m[PSR_Z] = 1'b1;
            m[PSR_L] = 1'b1;
        end
        return m;
    endfunction

    function automatic decode_t decode(input logic [3:0] op, input logic [3:0] ext);
        decode_t d;
        d = '0;
        if (op == OP_RTYPE) begin
            if (arith_valid(ext)) begin
                d.kind = K_ALU;
                d.alu  = arith_alu(ext);
            end
        end else if (arith_valid(op)) begin
            d.kind  = K_ALU;
            d.alu   = arith_alu(op);
            d.b_imm = 1'b1;
            d.zext  = (op == CODE_AND) || (op == CODE_OR) || (op == CODE_XOR);
        end else begin
            case (op)
                OP_LUI: begin
                    d.kind  = K_ALU;
                    d.alu   = ALU_LUI;
                    d.b_imm = 1'b1;
                end
                OP_SHIFT: begin
                    if (ext == EXT_LSH) begin
                        d.kind = K_ALU;
                        d.alu  = ALU_LSH;
                    end else if (ext[3:1] == 3'b000) begin
                        d.kind  = K_ALU;
                        d.alu   = ALU_LSH;
                        d.b_imm = 1'b1;
                    end
                end
                OP_SPECIAL: begin
                    case (ext)
                        EXT_LOAD:  d.kind = K_LOAD;
                        EXT_STOR:  d.kind = K_STOR;
                        EXT_JAL: begin
                            d.kind  = K_JAL;
                            d.alu   = ALU_JAL;
                            d.rf_wr = 1'b1;
                        end
                        EXT_JCOND: begin
                            d.kind = K_JCOND;
                            d.alu  = ALU_JCOND;
                        end
                        default: ;
                    endcase
                end
                OP_BCOND: d.kind = K_BCOND;
                default: ;
            endcase
        end
        if (d.kind == K_ALU) begin
            d.rf_wr     = (d.alu != ALU_CMP);
            d.flag_mask = flag_mask_of(d.alu);
        end
        return d;
    endfunction

endpackage

// File: rtl/ctrl_fsm_cond_eval.sv
// Branch/jump condition evaluator.
// Ports:
//   cond - condition field from the instruction (instr[11:8])
//   psr  - current architectural PSR
//   take - 1 when the condition holds
module cond_eval #(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] psr,
    output logic             take
);
    import bananachine_pkg::*;

    logic c, l, f, z, n;
    assign c = psr[PSR_C];
    assign l = psr[PSR_L];
    assign f = psr[PSR_F];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];

    logic unused_psr_bits;
    assign unused_psr_bits = ^{psr[WIDTH-1:8], psr[4:3], psr[1]};

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_HI: take = l;
            COND_LS: take = !l;
            COND_GT: take = n;
            COND_LE: take = !n;
            COND_FS: take = f;
            COND_FC: take = !f;
            COND_LO: take = !l && !z;
            COND_HS: take = l || z;
            COND_LT: take = !n && !z;
            COND_GE: take = n || z;
            COND_UC: take = 1'b1;
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle control unit for the Bananachine datapath.
// Fetches over a req/ready handshake, decodes, drives ALU/regfile/PC/memory
// controls and maintains the PSR.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   instr               - instruction register contents
//   psr_flags           - ALU flag vector (C0 L2 F5 Z6 N7)
//   mem_ready           - memory completes the current request
//   alu_cont, b_sel, imm_zext      - ALU controls
//   rf_we, wb_sel                  - register-file write controls
//   ir_en, pc_en, pc_sel           - IR latch and PC update controls
//   addr_sel, mem_req, mem_we      - memory controls
//   psr                            - architectural PSR
//
// state     | meaning
// FETCH     | request instruction at PC, wait for mem_ready
// DECODE    | one idle cycle while the IR settles
// EXEC      | drive datapath for the instruction, update PSR
// MEM       | LOAD/STOR data access at Raddr, wait for mem_ready
module ctrl_fsm #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         instr,
    input  logic [WIDTH-1:0]         psr_flags,
    input  logic                     mem_ready,
    output logic [ALU_CONT_BITS-1:0] alu_cont,
    output logic                     b_sel,
    output logic                     imm_zext,
    output logic                     rf_we,
    output logic [1:0]               wb_sel,
    output logic                     ir_en,
    output logic                     pc_en,
    output logic [1:0]               pc_sel,
    output logic                     addr_sel,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         psr
);
    import bananachine_pkg::*;

    logic [1:0]       state;
    decode_t          dec;
    logic             cond_take;
    logic [WIDTH-1:0] psr_mask;

    assign dec      = decode(instr[15:12], instr[7:4]);
    assign psr_mask = WIDTH'(dec.flag_mask);

    logic unused_rsrc;
    assign unused_rsrc = ^instr[3:0];

    cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .cond (instr[11:8]),
        .psr  (psr),
        .take (cond_take)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            psr   <= '0;
        end else begin
            case (state)
                ST_FETCH:  if (mem_ready) state <= ST_DECODE;
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    psr   <= (psr & ~psr_mask) | (psr_flags & psr_mask);
                    state <= (dec.kind == K_LOAD || dec.kind == K_STOR) ? ST_MEM : ST_FETCH;
                end
                ST_MEM:    if (mem_ready) state <= ST_FETCH;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Outputs are Mealy on mem_ready; gating with reset keeps every control
    // low during the reset cycle, whatever state is being left.
    always_comb begin
        alu_cont = '0;
        b_sel    = 1'b0;
        imm_zext = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_INC;
        addr_sel = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_en   = mem_ready;
                end
                ST_EXEC: begin
                    case (dec.kind)
                        K_ALU: begin
                            alu_cont = ALU_CONT_BITS'(dec.alu);
                            b_sel    = dec.b_imm;
                            imm_zext = dec.zext;
                            rf_we    = dec.rf_wr;
                            pc_en    = 1'b1;
                        end
                        K_LOAD, K_STOR: addr_sel = 1'b1;
                        K_BCOND: begin
                            pc_en  = 1'b1;
                            pc_sel = cond_take ? PC_SEL_DISP : PC_SEL_INC;
                        end
                        K_JCOND: begin
                            alu_cont = ALU_CONT_BITS'(ALU_JCOND);
                            pc_en    = 1'b1;
                            pc_sel   = cond_take ? PC_SEL_REG : PC_SEL_INC;
                        end
                        K_JAL: begin
                            alu_cont = ALU_CONT_BITS'(ALU_JAL);
                            rf_we    = 1'b1;
                            wb_sel   = WB_PC1;
                            pc_en    = 1'b1;
                            pc_sel   = PC_SEL_REG;
                        end
                        default: pc_en = 1'b1;
                    endcase
                end
                ST_MEM: begin
                    addr_sel = 1'b1;
                    mem_req  = 1'b1;
                    mem_we   = (dec.kind == K_STOR);
                    if (mem_ready) begin
                        pc_en = 1'b1;
                        if (dec.kind == K_LOAD) begin
                            rf_we  = 1'b1;
                            wb_sel = WB_MEM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
